demux1to2_buf: RTL and testbench

Registered 1:2 demultiplexer that steers a DATA_WIDTH-bit word from a single producer to one of two consumers, the inverse of the 2:1 select path used throughout the datapath. Each output has a one-entry holding slot with valid/ready handshaking, so a stalled consumer back-pressures only words addressed to it. It sits between a single result source, such as the writeback or forwarding stage, and two downstream pipeline consumers.

---
 rtl/demux1to2_buf_if.sv | 23 ++
 rtl/demux1to2_buf.sv | 105 ++++++++++
 tb/tb_demux1to2_buf.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux1to2_buf_if.sv
// demux1to2_buf_if: producer/consumer bundle for the 1:2 registered demux.
// master = producer + consumers side, slave = the demux itself.
interface demux1to2_buf_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                       sel;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic [1:0]                 out_valid;
  logic [1:0][DATA_WIDTH-1:0] out_data;
  logic [1:0]                 out_ready;

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux1to2_buf.sv
// demux1to2_buf: registered 1:2 demultiplexer with a one-entry holding slot
// per output and valid/ready handshaking on every side. A stalled consumer
// only blocks words addressed to it.
// Optional feature macro: DEMUX_STATS_EN adds the xfer_cnt port with a
// wrapping 16-bit delivered-word counter per output.
module demux1to2_buf #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  demux1to2_buf_if.slave     bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [1:0][15:0]   xfer_cnt
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t                r_state [2];
  logic [1:0][DATA_WIDTH-1:0] r_data;

  logic       w_sel_busy;
  logic       w_in_ready;
  logic       w_accept;
  logic [1:0] w_acc;
  logic [1:0] w_del;

  // Handshake decode: input readiness depends only on the addressed slot
  always_comb begin
    w_sel_busy = (r_state[bus.sel] == SLOT_FULL) && !bus.out_ready[bus.sel];
    w_in_ready = reset_n && !w_sel_busy;
    w_accept   = bus.in_valid && w_in_ready;
    w_acc[0]   = w_accept && !bus.sel;
    w_acc[1]   = w_accept &&  bus.sel;
    for (int unsigned i = 0; i < 2; i++) begin
      w_del[i] = (r_state[i] == SLOT_FULL) && bus.out_ready[i];
    end
  end

  // Per-slot EMPTY/FULL state machine with registered data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_state[i] <= SLOT_EMPTY;
      end
      r_data <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        case (r_state[i])
          SLOT_EMPTY: begin
            if (w_acc[i]) begin
              r_state[i] <= SLOT_FULL;
              r_data[i]  <= bus.in_data;
            end
          end
          SLOT_FULL: begin
            // Refill on the same edge as delivery keeps 1 word/cycle
            if (w_acc[i]) begin
              r_data[i] <= bus.in_data;
            end else if (w_del[i]) begin
              r_state[i] <= SLOT_EMPTY;
            end
          end
          default: r_state[i] <= SLOT_EMPTY;
        endcase
      end
    end
  end

  // Drive the bus outputs straight from the slot registers
  always_comb begin
    bus.in_ready = w_in_ready;
    for (int unsigned i = 0; i < 2; i++) begin
      bus.out_valid[i] = (r_state[i] == SLOT_FULL);
    end
    bus.out_data = r_data;
  end

`ifdef DEMUX_STATS_EN
  logic [1:0][15:0] r_xfer_cnt;

  // Delivered-word counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_xfer_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_del[i]) begin
          r_xfer_cnt[i] <= r_xfer_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Expose the counters
  always_comb begin
    xfer_cnt = r_xfer_cnt;
  end
`endif

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb_demux1to2_buf: directed and randomized bench for demux1to2_buf with a
// queue-based reference model checked on every falling clock edge.
module tb_demux1to2_buf;

  logic clk;
  logic reset_n;

  demux1to2_buf_if #(.DATA_WIDTH(64)) bus ();

`ifdef DEMUX_STATS_EN
  logic [1:0][15:0] xfer_cnt;
`endif

  demux1to2_buf #(.DATA_WIDTH(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-output FIFO of accepted, undelivered words
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  logic [63:0] mlast0, mlast1;
  int unsigned mcnt0, mcnt1;
  bit          chk_en = 0;
  bit          stall  = 0;

  // Events captured at the falling edge, applied at the next rising edge
  bit          nx_rst = 1;
  bit          nx_acc = 0;
  bit          nx_sel = 0;
  logic [63:0] nx_data = '0;
  bit [1:0]    nx_del = '0;

  // Compare process
  always @(negedge clk) begin
    logic [1:0]  e_valid;
    logic [63:0] e_d0, e_d1;
    logic        e_ready;
    e_valid = {mq1.size() != 0, mq0.size() != 0};
    e_d0    = (mq0.size() != 0) ? mq0[0] : mlast0;
    e_d1    = (mq1.size() != 0) ? mq1[0] : mlast1;
    if (bus.sel) e_ready = reset_n && (mq1.size() == 0 || bus.out_ready[1]);
    else         e_ready = reset_n && (mq0.size() == 0 || bus.out_ready[0]);
    if (chk_en) begin
      chk("in_ready",    {63'd0, bus.in_ready}, {63'd0, e_ready});
      chk("out_valid",   {62'd0, bus.out_valid}, {62'd0, e_valid});
      chk("out_data0",   bus.out_data[0], e_d0);
      chk("out_data1",   bus.out_data[1], e_d1);
`ifdef DEMUX_STATS_EN
      chk("xfer_cnt0",   {48'd0, xfer_cnt[0]}, {48'd0, mcnt0[15:0]});
      chk("xfer_cnt1",   {48'd0, xfer_cnt[1]}, {48'd0, mcnt1[15:0]});
`endif
    end
    stall   = bus.in_valid && !bus.in_ready;
    nx_rst  = !reset_n;
    nx_acc  = bus.in_valid && e_ready;
    nx_sel  = bus.sel;
    nx_data = bus.in_data;
    nx_del  = e_valid & bus.out_ready;
  end

  // Model update
  always @(posedge clk) begin
    if (nx_rst) begin
      mq0.delete(); mq1.delete();
      mlast0 = '0; mlast1 = '0;
      mcnt0 = 0; mcnt1 = 0;
      chk_en = 1;
    end else begin
      if (nx_del[0]) begin mlast0 = mq0.pop_front(); mcnt0++; end
      if (nx_del[1]) begin mlast1 = mq1.pop_front(); mcnt1++; end
      if (nx_acc) begin
        if (nx_sel) mq1.push_back(nx_data);
        else        mq0.push_back(nx_data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [63:0] d, input logic [1:0] r);
    bus.in_valid  = v;
    bus.sel       = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, 2'b00);
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 64'hAAAA_5555_AAAA_5555, 2'b00);

    // Reset held 3 cycles with a word offered
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", {62'd0, bus.out_valid}, 64'd0);
      chk("rst_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("rst_data0", bus.out_data[0], 64'd0);
      chk("rst_data1", bus.out_data[1], 64'd0);
      next_cycle();
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0, 2'b11);
    @(negedge clk);
    chk("rel_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rel_valid", {62'd0, bus.out_valid}, 64'd0);
    next_cycle();

    // Single route to out[1]
    drive(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 2'b11);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("route_valid", {62'd0, bus.out_valid}, 64'h2);
    chk("route_data1", bus.out_data[1], 64'hDEAD_BEEF_0000_0001);
    next_cycle();
    @(negedge clk);
    chk("route_gone", {62'd0, bus.out_valid}, 64'h0);
    next_cycle();

    // Back-pressure on out[0]
    drive(1'b1, 1'b0, 64'h1, 2'b00);
    next_cycle();
    bus.in_data = 64'h2;
    repeat (2) begin
      @(negedge clk);
      chk("bp_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold",  bus.out_data[0], 64'h1);
      next_cycle();
    end
    bus.out_ready = 2'b01;
    @(negedge clk);
    chk("bp_ready_up", {63'd0, bus.in_ready}, 64'd1);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_B_valid", {62'd0, bus.out_valid}, 64'h1);
    chk("bp_B_data",  bus.out_data[0], 64'h2);
    next_cycle();
    @(negedge clk);
    chk("bp_done", {62'd0, bus.out_valid}, 64'h0);

    // Isolation: slot 1 stalled, out[0] still flows
    drive(1'b1, 1'b1, 64'h9, 2'b01);
    next_cycle();
    bus.sel = 1'b0;
    bus.in_data = 64'h5;
    @(negedge clk);
    chk("iso_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("iso_full1", {62'd0, bus.out_valid}, 64'h2);
    next_cycle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("iso_both",  {62'd0, bus.out_valid}, 64'h3);
    chk("iso_data0", bus.out_data[0], 64'h5);
    chk("iso_data1", bus.out_data[1], 64'h9);
    next_cycle();
    @(negedge clk);
    chk("iso_after", {62'd0, bus.out_valid}, 64'h2);
    chk("iso_keep1", bus.out_data[1], 64'h9);
    bus.out_ready = 2'b11;
    next_cycle();

    // Streaming, alternating outputs, fresh counters
    do_reset();
    bus.out_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.sel      = k[0];
      bus.in_data  = 64'h10 + 64'(k);
      @(negedge clk);
      chk("stream_ready", {63'd0, bus.in_ready}, 64'd1);
      if (k > 0) begin
        chk("stream_valid", {62'd0, bus.out_valid}, ((k - 1) % 2 == 0) ? 64'h1 : 64'h2);
        chk("stream_data", bus.out_data[(k - 1) % 2], 64'h10 + 64'(k - 1));
      end
      next_cycle();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", bus.out_data[1], 64'h17);
    next_cycle();
    @(negedge clk);
    chk("stream_empty", {62'd0, bus.out_valid}, 64'h0);
`ifdef DEMUX_STATS_EN
    chk("stream_cnt0", {48'd0, xfer_cnt[0]}, 64'd4);
    chk("stream_cnt1", {48'd0, xfer_cnt[1]}, 64'd4);
`endif
    next_cycle();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(249) != 0);
      if (!stall) begin
        bus.in_valid = ($urandom_range(3) != 0);
        bus.sel      = $urandom_range(1);
        bus.in_data  = {$urandom, $urandom};
      end
      bus.out_ready = 2'($urandom_range(3));
      next_cycle();
    end
    reset_n = 1'b1;

`ifdef DEMUX_STATS_EN
    // Counter wrap: 65537 deliveries on out[0]
    do_reset();
    bus.out_ready = 2'b01;
    bus.sel       = 1'b0;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      bus.in_data = 64'(n);
      next_cycle();
    end
    bus.in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("wrap_cnt0", {48'd0, xfer_cnt[0]}, 64'd1);
    chk("wrap_cnt1", {48'd0, xfer_cnt[1]}, 64'd0);
    next_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
